multicycle_main_fsm: RTL and testbench

- Main control sequencer for the multicycle ARMv4 core.
- Walks each instruction through fetch, decode, execute, memory and writeback over several cycles of one shared ALU, memory port and register file.
- Drives the datapath mux selects and the raw write requests (RegW, MemW, NextPC, Branch). The downstream condition unit qualifies these with CondEx.
- Adds a memory-ready handshake, a memory timeout and a retired-instruction counter.

---
 rtl/multicycle_main_fsm.sv | 165 ++++++++++++++++
 tb/tb_multicycle_main_fsm.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_fsm.sv
// Main control sequencer for the multicycle ARMv4 core.
// Moore datapath selects, raw write requests, memory timeout, retire count.
module multicycle_main_fsm #(
   parameter int MAX_WAIT = 15,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       Op,
   input  logic [5:0]       Funct,
   input  logic             MemReady,
   output logic             IRWrite,
   output logic             NextPC,
   output logic             AdrSrc,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ResultSrc,
   output logic             ALUOp,
   output logic             RegW,
   output logic             MemW,
   output logic             Branch,
   output logic             InstrDone,
   output logic [CNT_W-1:0] InstrCount,
   output logic             Fault
);

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
      EXECUTER, EXECUTEI, ALUWB, BRANCH, FAULT
   } state_t;

   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   state_t           state_q, state_d;
   logic [7:0]       wait_q, wait_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mem_state, mem_wait, timeout, done;

   // Only I and L/S are decoded here; the ALU decoder handles the rest.
   logic unused_funct;
   assign unused_funct = ^Funct[4:1];

   assign mem_state = (state_q == FETCH) || (state_q == MEMREAD) ||
                      (state_q == MEMWRITE);
   assign mem_wait  = mem_state && !MemReady;
   assign timeout   = mem_wait && (wait_q == WAIT_LAST);

   always_comb begin
      state_d   = state_q;
      IRWrite   = 1'b0;
      NextPC    = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      ResultSrc = 2'b00;
      ALUOp     = 1'b0;
      RegW      = 1'b0;
      MemW      = 1'b0;
      Branch    = 1'b0;
      Fault     = 1'b0;
      unique case (state_q)
         FETCH: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            IRWrite   = MemReady;
            NextPC    = MemReady;
            if (MemReady)     state_d = DECODE;
            else if (timeout) state_d = FAULT;
         end
         DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            unique case (Op)
               2'b00:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
               2'b01:   state_d = MEMADR;
               2'b10:   state_d = BRANCH;
               default: state_d = FETCH;
            endcase
         end
         MEMADR: begin
            ALUSrcB = 2'b01;
            state_d = Funct[0] ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            AdrSrc = 1'b1;
            if (MemReady)     state_d = MEMWB;
            else if (timeout) state_d = FAULT;
         end
         MEMWB: begin
            ResultSrc = 2'b01;
            RegW      = 1'b1;
            state_d   = FETCH;
         end
         MEMWRITE: begin
            AdrSrc = 1'b1;
            MemW   = 1'b1;
            if (MemReady)     state_d = FETCH;
            else if (timeout) state_d = FAULT;
         end
         EXECUTER: begin
            ALUOp   = 1'b1;
            state_d = ALUWB;
         end
         EXECUTEI: begin
            ALUSrcB = 2'b01;
            ALUOp   = 1'b1;
            state_d = ALUWB;
         end
         ALUWB: begin
            RegW    = 1'b1;
            state_d = FETCH;
         end
         BRANCH: begin
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            Branch    = 1'b1;
            state_d   = FETCH;
         end
         default: begin
            Fault = 1'b1;
         end
      endcase

      done = (state_d == FETCH) && (state_q != FETCH) &&
             (state_q != FAULT);

      if (reset) begin
         IRWrite = 1'b0;
         NextPC  = 1'b0;
         RegW    = 1'b0;
         MemW    = 1'b0;
         Branch  = 1'b0;
         done    = 1'b0;
      end
      InstrDone = done;

      // A fresh entry into a waiting state restarts its timeout window.
      if ((state_d != state_q) && ((state_d == FETCH) ||
          (state_d == MEMREAD) || (state_d == MEMWRITE)))
         wait_d = 8'd0;
      else if (mem_wait)
         wait_d = wait_q + 8'd1;
      else
         wait_d = wait_q;

      cnt_d = done ? cnt_q + CNT_W'(1) : cnt_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH;
         wait_q  <= 8'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         cnt_q   <= cnt_d;
      end
   end

   assign InstrCount = cnt_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Self-checking bench for multicycle_main_fsm: per-instruction
// cycle traces built from the instruction rules, random timing.
module tb_multicycle_main_fsm;

   localparam int MAXW = 15;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  Op = 2'b00;
   logic [5:0]  Funct = 6'd0;
   logic        MemReady = 1'b0;
   logic        IRWrite, NextPC, AdrSrc, ALUSrcA, ALUOp;
   logic [1:0]  ALUSrcB, ResultSrc;
   logic        RegW, MemW, Branch, InstrDone, Fault;
   logic [31:0] InstrCount;
   logic [14:0] outv;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] exp_cnt = 0;

   multicycle_main_fsm #(.MAX_WAIT(MAXW), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
      .MemReady(MemReady), .IRWrite(IRWrite), .NextPC(NextPC),
      .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ResultSrc(ResultSrc), .ALUOp(ALUOp), .RegW(RegW),
      .MemW(MemW), .Branch(Branch), .InstrDone(InstrDone),
      .InstrCount(InstrCount), .Fault(Fault)
   );

   always #5 clk = ~clk;

   assign outv = {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB,
                  ResultSrc, ALUOp, RegW, MemW, Branch,
                  InstrDone, Fault};

   function automatic logic [14:0] v(
      input logic irw, npc, adr, asa,
      input logic [1:0] asb, rs,
      input logic aop, rw, mw, br, dn, flt);
      return {irw, npc, adr, asa, asb, rs, aop, rw, mw, br, dn, flt};
   endfunction

   function automatic logic rnd();
      return logic'($urandom_range(0, 1));
   endfunction

   task automatic chk_out(input string tag, input logic [14:0] e);
      n_cmp++;
      assert (outv === e) else begin
         n_bad++;
         $error("FAIL %s outputs: got %b want %b", tag, outv, e);
      end
   endtask

   task automatic chk_cnt(input string tag);
      n_cmp++;
      assert (InstrCount === exp_cnt) else begin
         n_bad++;
         $error("FAIL %s count: got %0d want %0d", tag, InstrCount,
                exp_cnt);
      end
   endtask

   // One clock cycle: drive MemReady, check, advance past the edge.
   task automatic cyc(input string tag, input logic mr,
                      input logic [14:0] e);
      MemReady = mr;
      #1;
      chk_out(tag, e);
      chk_cnt(tag);
      @(posedge clk);
      #1;
      if (e[1]) exp_cnt = exp_cnt + 1;
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      MemReady = 1'b1;
      @(posedge clk);
      #1;
      exp_cnt = 0;
      chk_out(tag, v(0,0,0,1,2'b10,2'b10,0,0,0,0,0,0));
      chk_cnt(tag);
      reset = 1'b0;
   endtask

   task automatic fetch(input int fw);
      for (int i = 0; i < fw; i++)
         cyc("fetch_wait", 1'b0, v(0,0,0,1,2'b10,2'b10,0,0,0,0,0,0));
      cyc("fetch", 1'b1, v(1,1,0,1,2'b10,2'b10,0,0,0,0,0,0));
   endtask

   // Full instruction trace: fw fetch stalls, mw data-memory stalls.
   task automatic instr(input logic [1:0] op, input logic [5:0] fn,
                        input int fw, input int mw);
      Op = op;
      Funct = fn;
      fetch(fw);
      cyc("decode", rnd(),
          v(0,0,0,1,2'b10,2'b10,0,0,0,0,op == 2'b11,0));
      case (op)
         2'b00: begin
            cyc("execute", rnd(),
                v(0,0,0,0,fn[5] ? 2'b01 : 2'b00,2'b00,1,0,0,0,0,0));
            cyc("aluwb", rnd(), v(0,0,0,0,2'b00,2'b00,0,1,0,0,1,0));
         end
         2'b01: begin
            cyc("memadr", rnd(), v(0,0,0,0,2'b01,2'b00,0,0,0,0,0,0));
            if (fn[0]) begin
               for (int i = 0; i < mw; i++)
                  cyc("memread_wait", 1'b0,
                      v(0,0,1,0,2'b00,2'b00,0,0,0,0,0,0));
               cyc("memread", 1'b1, v(0,0,1,0,2'b00,2'b00,0,0,0,0,0,0));
               cyc("memwb", rnd(), v(0,0,0,0,2'b00,2'b01,0,1,0,0,1,0));
            end else begin
               for (int i = 0; i < mw; i++)
                  cyc("memwrite_wait", 1'b0,
                      v(0,0,1,0,2'b00,2'b00,0,0,1,0,0,0));
               cyc("memwrite", 1'b1, v(0,0,1,0,2'b00,2'b00,0,0,1,0,1,0));
            end
         end
         2'b10: cyc("branch", rnd(), v(0,0,0,0,2'b01,2'b10,0,0,0,1,1,0));
         default: ;
      endcase
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      do_reset("reset");

      instr(2'b00, 6'b000000, 0, 0);
      instr(2'b01, 6'b000001, 0, 3);
      instr(2'b01, 6'b000000, 0, 2);
      for (int i = 0; i < 10; i++)
         instr(2'b10, 6'($urandom), 0, 0);
      instr(2'b11, 6'($urandom), 0, 0);
      instr(2'b00, 6'b100000, 0, 0);

      // Ready arriving on the last allowed stall cycle must not fault.
      instr(2'b00, 6'b000000, MAXW - 1, 0);
      instr(2'b01, 6'b000001, 0, MAXW - 1);
      instr(2'b01, 6'b000000, MAXW - 1, MAXW - 1);

      for (int i = 0; i < 40; i++)
         instr(2'($urandom), 6'($urandom), $urandom_range(0, 4),
               $urandom_range(0, 4));

      // Fetch timeout: sticky FAULT, frozen count, reset recovers.
      for (int i = 0; i < MAXW; i++)
         cyc("to_wait", 1'b0, v(0,0,0,1,2'b10,2'b10,0,0,0,0,0,0));
      for (int i = 0; i < 6; i++)
         cyc("fault", rnd(), v(0,0,0,0,2'b00,2'b00,0,0,0,0,0,1));
      do_reset("fault_reset");
      instr(2'b11, 6'd0, 0, 0);

      // Data-memory timeout in MEMREAD.
      Op = 2'b01;
      Funct = 6'b000001;
      fetch(0);
      cyc("decode", 1'b0, v(0,0,0,1,2'b10,2'b10,0,0,0,0,0,0));
      cyc("memadr", 1'b0, v(0,0,0,0,2'b01,2'b00,0,0,0,0,0,0));
      for (int i = 0; i < MAXW; i++)
         cyc("rd_to_wait", 1'b0, v(0,0,1,0,2'b00,2'b00,0,0,0,0,0,0));
      cyc("rd_fault", 1'b1, v(0,0,0,0,2'b00,2'b00,0,0,0,0,0,1));
      do_reset("rd_fault_reset");

      // Reset in the middle of a store.
      instr(2'b10, 6'd0, 0, 0);
      Op = 2'b01;
      Funct = 6'b000000;
      fetch(1);
      cyc("decode", 1'b1, v(0,0,0,1,2'b10,2'b10,0,0,0,0,0,0));
      cyc("memadr", 1'b1, v(0,0,0,0,2'b01,2'b00,0,0,0,0,0,0));
      cyc("memwrite_wait", 1'b0, v(0,0,1,0,2'b00,2'b00,0,0,1,0,0,0));
      reset = 1'b1;
      MemReady = 1'b1;
      #1;
      chk_out("memwrite_reset", v(0,0,1,0,2'b00,2'b00,0,0,0,0,0,0));
      @(posedge clk);
      #1;
      exp_cnt = 0;
      reset = 1'b0;
      instr(2'b00, 6'b100000, 0, 0);
      instr(2'b01, 6'b000001, 1, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
